// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared constants for the RV32I execute datapath: base opcodes and the funct3
// encodings used by the ALU and the branch comparator.
// No ports (package).
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [6:0] OP_ALU         = 7'b0110011;
    localparam logic [6:0] OP_ALUI        = 7'b0010011;
    localparam logic [6:0] OP_LOAD        = 7'b0000011;
    localparam logic [6:0] OP_STORE       = 7'b0100011;
    localparam logic [6:0] OP_BRANCH      = 7'b1100011;
    localparam logic [6:0] OP_JAL         = 7'b1101111;
    localparam logic [6:0] OP_JALR        = 7'b1100111;
    localparam logic [6:0] OP_LUI         = 7'b0110111;
    localparam logic [6:0] OP_AUIPC       = 7'b0010111;
    localparam logic [6:0] OP_ENVIRONMENT = 7'b1110011;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } alu_f3_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_f3_e;

endpackage

// File: rtl/rv32i_exec_unit_alu.sv
// -----------------------------------------------------------------------------
// rv32i_exec_unit_alu
// Integer ALU with a single result register loaded when i_en is high.
// Ports:
//   clk, rst_n   clock and asynchronous active-high reset
//   i_en         load enable for o_res
//   i_funct3     operation select
//   i_f7b5       instr[30]: SUB (R-type only) and SRA select
//   i_is_rtype   instr[5]: operand B from register instead of immediate
//   i_a, i_reg_b, i_imm  operands
//   o_res        registered result
// -----------------------------------------------------------------------------
module rv32i_exec_unit_alu
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic [2:0]      i_funct3,
    input  logic            i_f7b5,
    input  logic            i_is_rtype,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_reg_b,
    input  logic [XLEN-1:0] i_imm,
    output logic [XLEN-1:0] o_res
);

    logic        [XLEN-1:0] w_b;
    logic signed [XLEN-1:0] w_a_s;
    logic signed [XLEN-1:0] w_b_s;
    logic        [4:0]      w_shamt;
    logic        [XLEN-1:0] w_result;
    logic        [XLEN-1:0] r_res;

    assign w_b     = i_is_rtype ? i_reg_b : i_imm;
    assign w_a_s   = $signed(i_a);
    assign w_b_s   = $signed(w_b);
    assign w_shamt = w_b[4:0];

    always_comb begin
        w_result = '0;
        case (alu_f3_e'(i_funct3))
            // instr[30] is an immediate bit for ADDI, so only R-type may subtract
            F3_ADD:  w_result = (i_is_rtype && i_f7b5) ? i_a - w_b : i_a + w_b;
            F3_SLL:  w_result = i_a << w_shamt;
            F3_SLT:  w_result = XLEN'(w_a_s < w_b_s);
            F3_SLTU: w_result = XLEN'(i_a < w_b);
            F3_XOR:  w_result = i_a ^ w_b;
            F3_SR:   w_result = i_f7b5 ? XLEN'(w_a_s >>> w_shamt) : i_a >> w_shamt;
            F3_OR:   w_result = i_a | w_b;
            F3_AND:  w_result = i_a & w_b;
            default: w_result = '0;
        endcase
    end

    // ---- result register ----
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_res <= '0;
        end else if (i_en) begin
            r_res <= w_result;
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/rv32i_exec_unit_branch_unit.sv
// -----------------------------------------------------------------------------
// rv32i_exec_unit_branch_unit
// Branch comparator on rs1/rs2 with a decision register loaded when i_en is high.
// Ports:
//   clk, rst_n   clock and asynchronous active-high reset
//   i_en         load enable for o_taken
//   i_funct3     comparison select
//   i_rs1, i_rs2 operands
//   o_taken      registered branch decision
// -----------------------------------------------------------------------------
module rv32i_exec_unit_branch_unit
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_taken
);

    logic signed [XLEN-1:0] w_rs1_s;
    logic signed [XLEN-1:0] w_rs2_s;
    logic                   w_taken;
    logic                   r_taken;

    assign w_rs1_s = $signed(i_rs1);
    assign w_rs2_s = $signed(i_rs2);

    always_comb begin
        w_taken = 1'b0;
        case (br_f3_e'(i_funct3))
            F3_BEQ:  w_taken = (i_rs1 == i_rs2);
            F3_BNE:  w_taken = (i_rs1 != i_rs2);
            F3_BLT:  w_taken = (w_rs1_s <  w_rs2_s);
            F3_BGE:  w_taken = (w_rs1_s >= w_rs2_s);
            F3_BLTU: w_taken = (i_rs1 <  i_rs2);
            F3_BGEU: w_taken = (i_rs1 >= i_rs2);
            // 010 and 011 are not branch encodings
            default: w_taken = 1'b0;
        endcase
    end

    // ---- decision register ----
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_taken <= 1'b0;
        end else if (i_en) begin
            r_taken <= w_taken;
        end
    end

    assign o_taken = r_taken;

endmodule

// File: rtl/rv32i_exec_unit_imm_decoder.sv
// -----------------------------------------------------------------------------
// rv32i_exec_unit_imm_decoder
// Purely combinational immediate formatter; picks the I/S/B/U/J layout from
// the opcode and yields zero for opcodes without an immediate.
// Ports:
//   i_instr  in   32    instruction word
//   o_imm    out  XLEN  formatted immediate
// -----------------------------------------------------------------------------
module rv32i_exec_unit_imm_decoder
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_instr[6:0])
            OP_ALUI, OP_LOAD, OP_JALR, OP_ENVIRONMENT:
                o_imm = XLEN'($signed(i_instr[31:20]));
            OP_STORE:
                o_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
            OP_BRANCH:
                o_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                       i_instr[11:8], 1'b0}));
            OP_LUI, OP_AUIPC:
                o_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
            OP_JAL:
                o_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                       i_instr[30:21], 1'b0}));
            default:
                o_imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_exec_unit.sv
// -----------------------------------------------------------------------------
// rv32i_exec_unit
// RV32I execute block: immediate decoder, ALU and branch comparator.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active HIGH despite the name
//   instr        instruction being executed
//   alu_en       load enable for alu_res
//   br_en        load enable for br_taken
//   reg_data_1   rs1 value
//   reg_data_2   rs2 value
//   imm          combinational immediate from instr
//   alu_res      registered ALU result (1 clk latency)
//   br_taken     registered branch decision (1 clk latency)
// -----------------------------------------------------------------------------
module rv32i_exec_unit
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    input  logic            alu_en,
    input  logic            br_en,
    input  logic [XLEN-1:0] reg_data_1,
    input  logic [XLEN-1:0] reg_data_2,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] alu_res,
    output logic            br_taken
);

    logic [XLEN-1:0] w_imm;

    rv32i_exec_unit_imm_decoder #(.XLEN(XLEN)) u_imm_decoder (
        .i_instr (instr),
        .o_imm   (w_imm)
    );

    rv32i_exec_unit_alu #(.XLEN(XLEN)) u_alu (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (alu_en),
        .i_funct3   (instr[14:12]),
        .i_f7b5     (instr[30]),
        .i_is_rtype (instr[5]),
        .i_a        (reg_data_1),
        .i_reg_b    (reg_data_2),
        .i_imm      (w_imm),
        .o_res      (alu_res)
    );

    rv32i_exec_unit_branch_unit #(.XLEN(XLEN)) u_branch_unit (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (br_en),
        .i_funct3 (instr[14:12]),
        .i_rs1    (reg_data_1),
        .i_rs2    (reg_data_2),
        .o_taken  (br_taken)
    );

    assign imm = w_imm;

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_rv32i_exec_unit
// Directed bench for rv32i_exec_unit. Inputs change on the falling edge,
// registered outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_rv32i_exec_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_en;
    logic        br_en;
    logic [31:0] reg_data_1;
    logic [31:0] reg_data_2;
    logic [31:0] imm;
    logic [31:0] alu_res;
    logic        br_taken;

    int n_tests = 0;
    int n_fail  = 0;

    rv32i_exec_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .alu_en     (alu_en),
        .br_en      (br_en),
        .reg_data_1 (reg_data_1),
        .reg_data_2 (reg_data_2),
        .imm        (imm),
        .alu_res    (alu_res),
        .br_taken   (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One enabled edge: drive on the falling edge, sample just after the rising edge.
    task automatic pulse(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic ae, input logic be);
        @(negedge clk);
        instr = ins; reg_data_1 = a; reg_data_2 = b; alu_en = ae; br_en = be;
        @(posedge clk);
        #1;
        alu_en = 1'b0; br_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; instr = 32'hFFF00093; reg_data_1 = 32'd5; reg_data_2 = 32'd5;
        alu_en = 1'b1; br_en = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (alu_res !== 32'h0) begin
            n_fail++; $display("FAIL reset_alu: got %h want %h", alu_res, 32'h0);
        end
        n_tests++;
        if (br_taken !== 1'b0) begin
            n_fail++; $display("FAIL reset_br: got %b want %b", br_taken, 1'b0);
        end
        @(negedge clk);
        alu_en = 1'b0; br_en = 1'b0; rst_n = 1'b0;
    endtask

    task automatic test_addi();
        @(negedge clk);
        instr = 32'hFFF00093; reg_data_1 = 32'd5; reg_data_2 = 32'd0;
        #1;
        n_tests++;
        if (imm !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL addi_imm: got %h want %h", imm, 32'hFFFFFFFF);
        end
        alu_en = 1'b1;
        @(posedge clk); #1;
        alu_en = 1'b0;
        n_tests++;
        if (alu_res !== 32'd4) begin
            n_fail++; $display("FAIL addi_res: got %h want %h", alu_res, 32'd4);
        end
        @(negedge clk);
        reg_data_1 = 32'd100;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (alu_res !== 32'd4) begin
            n_fail++; $display("FAIL addi_hold: got %h want %h", alu_res, 32'd4);
        end
    endtask

    task automatic test_alu_rtype();
        logic [31:0] ins [10] = '{32'h40000033, 32'h40005033, 32'h00005033, 32'h00003033,
                                  32'h00002033, 32'h00000033, 32'h00004033, 32'h00006033,
                                  32'h00007033, 32'h00001033};
        logic [31:0] a   [10] = '{32'd3, 32'h80000000, 32'h80000000, 32'd1,
                                  32'd1, 32'd3, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                  32'hF0F0F0F0, 32'd1};
        logic [31:0] b   [10] = '{32'd5, 32'd4, 32'd4, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'd5, 32'hFF00FF00, 32'hFF00FF00,
                                  32'hFF00FF00, 32'h00000023};
        // SUB, SRA, SRL, SLTU, SLT, ADD, XOR, OR, AND, SLL (amount 0x23 -> 3)
        logic [31:0] exp [10] = '{32'hFFFFFFFE, 32'hF8000000, 32'h08000000, 32'd1,
                                  32'd0, 32'd8, 32'h0FF00FF0, 32'hFFF0FFF0,
                                  32'hF000F000, 32'd8};
        for (int i = 0; i < 10; i++) begin
            pulse(ins[i], a[i], b[i], 1'b1, 1'b0);
            n_tests++;
            if (alu_res !== exp[i]) begin
                n_fail++;
                $display("FAIL rtype[%0d] instr=%h: got %h want %h", i, ins[i], alu_res, exp[i]);
            end
        end
    endtask

    task automatic test_alu_itype();
        // ADDI with instr[30]=1 (imm 0x400), SRAI 4, SRLI 4, SLTIU -1; rs2 is a decoy
        logic [31:0] ins [4] = '{32'h40000093, 32'h40405093, 32'h00405093, 32'hFFF03093};
        logic [31:0] a   [4] = '{32'd5, 32'h80000000, 32'h80000000, 32'd1};
        logic [31:0] exp [4] = '{32'h00000405, 32'hF8000000, 32'h08000000, 32'd1};
        for (int i = 0; i < 4; i++) begin
            pulse(ins[i], a[i], 32'h7, 1'b1, 1'b0);
            n_tests++;
            if (alu_res !== exp[i]) begin
                n_fail++;
                $display("FAIL itype[%0d] instr=%h: got %h want %h", i, ins[i], alu_res, exp[i]);
            end
        end
    endtask

    task automatic test_branch();
        // BLT, BLTU, BGEU, f3=010, BEQ, BNE, BGE, f3=011
        logic [31:0] ins [8] = '{32'h00004063, 32'h00006063, 32'h00007063, 32'h00002063,
                                 32'h00000063, 32'h00001063, 32'h00005063, 32'h00003063};
        logic [31:0] a   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'd7, 32'd7, 32'd1, 32'hFFFFFFFF};
        logic [31:0] b   [8] = '{32'd1, 32'd1, 32'd1, 32'd1,
                                 32'd7, 32'd7, 32'hFFFFFFFF, 32'd1};
        logic        exp [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            pulse(ins[i], a[i], b[i], 1'b0, 1'b1);
            n_tests++;
            if (br_taken !== exp[i]) begin
                n_fail++;
                $display("FAIL branch[%0d] instr=%h: got %b want %b", i, ins[i], br_taken, exp[i]);
            end
        end
        // br_en low: a taken BEQ must not load
        pulse(32'h00000063, 32'd9, 32'd9, 1'b0, 1'b0);
        n_tests++;
        if (br_taken !== 1'b0) begin
            n_fail++; $display("FAIL branch_hold: got %b want %b", br_taken, 1'b0);
        end
    endtask

    task automatic test_imm();
        // B (offset -4), JAL, LUI, S (-4), AUIPC, LOAD (-2048), JALR, EBREAK, R-type, unknown
        logic [31:0] ins [10] = '{32'hFE000EE3, 32'h0080006F, 32'h123450B7, 32'hFE000E23,
                                  32'h00001017, 32'h80002003, 32'h00408067, 32'h00100073,
                                  32'h40000033, 32'h7FFFFFFF};
        logic [31:0] exp [10] = '{32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'hFFFFFFFC,
                                  32'h00001000, 32'hFFFFF800, 32'h00000004, 32'h00000001,
                                  32'h00000000, 32'h00000000};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            instr = ins[i];
            #1;
            n_tests++;
            if (imm !== exp[i]) begin
                n_fail++;
                $display("FAIL imm[%0d] instr=%h: got %h want %h", i, ins[i], imm, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        // ADD with both enables: funct3 000 is also BEQ
        pulse(32'h00000033, 32'd7, 32'd7, 1'b1, 1'b1);
        n_tests++;
        if (alu_res !== 32'd14) begin
            n_fail++; $display("FAIL both_alu: got %h want %h", alu_res, 32'd14);
        end
        n_tests++;
        if (br_taken !== 1'b1) begin
            n_fail++; $display("FAIL both_br: got %b want %b", br_taken, 1'b1);
        end
        // next edge immediately: SUB + BNE-free funct3 000 with unequal operands
        pulse(32'h40000033, 32'd10, 32'd3, 1'b1, 1'b1);
        n_tests++;
        if (alu_res !== 32'd7) begin
            n_fail++; $display("FAIL b2b_alu: got %h want %h", alu_res, 32'd7);
        end
        n_tests++;
        if (br_taken !== 1'b0) begin
            n_fail++; $display("FAIL b2b_br: got %b want %b", br_taken, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        pulse(32'hFFF00093, 32'd5, 32'd0, 1'b1, 1'b0);
        pulse(32'h00004063, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
        n_tests++;
        if (alu_res !== 32'd4 || br_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got %h/%b want %h/%b", alu_res, br_taken, 32'd4, 1'b1);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        n_tests++;
        if (alu_res !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_alu: got %h want %h", alu_res, 32'h0);
        end
        n_tests++;
        if (br_taken !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_br: got %b want %b", br_taken, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (alu_res !== 32'h0 || br_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_stay: got %h/%b want %h/%b", alu_res, br_taken, 32'h0, 1'b0);
        end
        // first enabled edge after release: ADDI -> 4, funct3 000 BEQ 5==5 -> 1
        pulse(32'hFFF00093, 32'd5, 32'd5, 1'b1, 1'b1);
        n_tests++;
        if (alu_res !== 32'd4 || br_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_reapply: got %h/%b want %h/%b", alu_res, br_taken, 32'd4, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_alu_rtype();
        test_alu_itype();
        test_branch();
        test_imm();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
